// File: rtl/encoder_menu_ctrl.sv
// Rotary-encoder menu controller: browse a bank of parameter registers, edit a
// shadow copy, and commit it downstream through a valid/ready write port.
module encoder_menu_ctrl #(
    parameter int NREG        = 4,
    parameter int VW          = 4,
    parameter int VMAX        = 15,
    parameter int WRAP        = 0,
    parameter int TIMEOUT_CYC = 27000000,
    localparam int SW         = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               step_up,
    input  logic               step_dn,
    input  logic               btn_press,
    output logic [SW-1:0]      sel,
    output logic               editing,
    output logic [VW-1:0]      edit_val,
    output logic               wr_valid,
    output logic [SW-1:0]      wr_addr,
    output logic [VW-1:0]      wr_data,
    input  logic               wr_ready,
    output logic [NREG*VW-1:0] cfg_flat
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(VMAX);
    localparam logic [SW-1:0] SEL_LAST = SW'(NREG - 1);

    typedef enum logic [1:0] {
        BROWSE = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_d, sel_step;
    logic            editing_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            wr_valid_d;
    logic [SW-1:0]   wr_addr_d;
    logic [VW-1:0]   wr_data_d;
    logic [VW-1:0]   cfg_q [NREG];
    logic [VW-1:0]   cfg_d [NREG];
    logic            up_only, dn_only;

    // Opposing pulses in the same cycle cancel out entirely.
    assign up_only = step_up & ~step_dn;
    assign dn_only = step_dn & ~step_up;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        wr_valid_d = wr_valid;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        for (int i = 0; i < NREG; i++) cfg_d[i] = cfg_q[i];

        sel_step = sel;
        if (up_only)      sel_step = (sel == SEL_LAST) ? '0 : sel + 1'b1;
        else if (dn_only) sel_step = (sel == '0) ? SEL_LAST : sel - 1'b1;

        case (state_q)
            BROWSE: begin
                sel_d = sel_step;
                if (btn_press) begin
                    shadow_d = cfg_q[sel_step];
                    cnt_d    = '0;
                    state_d  = EDIT;
                end
            end
            EDIT: begin
                if (btn_press) begin
                    wr_addr_d  = sel;
                    wr_data_d  = shadow_q;
                    wr_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = COMMIT;
                end else if (up_only) begin
                    cnt_d = '0;
                    if (shadow_q == V_MAX) shadow_d = (WRAP != 0) ? '0 : V_MAX;
                    else                   shadow_d = shadow_q + 1'b1;
                end else if (dn_only) begin
                    cnt_d = '0;
                    if (shadow_q == '0) shadow_d = (WRAP != 0) ? V_MAX : '0;
                    else                shadow_d = shadow_q - 1'b1;
                end else if (cnt_q == T_LAST) begin
                    cnt_d   = '0;
                    state_d = BROWSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                if (wr_ready) begin
                    cfg_d[wr_addr] = wr_data;
                    wr_valid_d     = 1'b0;
                    state_d        = BROWSE;
                end
            end
            default: state_d = BROWSE;
        endcase

        editing_d = (state_d == EDIT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= BROWSE;
            sel      <= '0;
            editing  <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < NREG; i++) cfg_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sel      <= sel_d;
            editing  <= editing_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            wr_valid <= wr_valid_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            for (int i = 0; i < NREG; i++) cfg_q[i] <= cfg_d[i];
        end
    end

    assign edit_val = (state_q == BROWSE) ? cfg_q[sel] : shadow_q;

    always_comb begin
        cfg_flat = '0;
        for (int i = 0; i < NREG; i++) cfg_flat[i*VW +: VW] = cfg_q[i];
    end

endmodule

// File: tb/tb_encoder_menu_ctrl.sv
// Directed bench for encoder_menu_ctrl: a saturating instance and a wrapping
// instance share stimulus; expected values are hand-computed constants.
module tb_encoder_menu_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        step_up = 1'b0, step_dn = 1'b0, btn_press = 1'b0, wr_ready = 1'b0;

    logic [1:0]  sel, wr_addr;
    logic        editing, wr_valid;
    logic [3:0]  edit_val, wr_data;
    logic [15:0] cfg_flat;

    logic [1:0]  w_sel, w_wr_addr;
    logic        w_editing, w_wr_valid;
    logic [3:0]  w_edit_val, w_wr_data;
    logic [15:0] w_cfg_flat;

    int n_checks = 0;
    int n_errors = 0;

    encoder_menu_ctrl #(.NREG(4), .VW(4), .VMAX(15), .WRAP(0), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rstn(rstn), .step_up(step_up), .step_dn(step_dn), .btn_press(btn_press),
        .sel(sel), .editing(editing), .edit_val(edit_val), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .cfg_flat(cfg_flat)
    );

    encoder_menu_ctrl #(.NREG(4), .VW(4), .VMAX(15), .WRAP(1), .TIMEOUT_CYC(100)) dut_wrap (
        .clk(clk), .rstn(rstn), .step_up(step_up), .step_dn(step_dn), .btn_press(btn_press),
        .sel(w_sel), .editing(w_editing), .edit_val(w_edit_val), .wr_valid(w_wr_valid),
        .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_ready(wr_ready), .cfg_flat(w_cfg_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn, input logic btn);
        step_up = up; step_dn = dn; btn_press = btn;
        tick();
        step_up = 1'b0; step_dn = 1'b0; btn_press = 1'b0;
    endtask

    logic [3:0] sel_seq [7] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd0, 4'd3};
    bit         saw_valid;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_cfg", 32'(cfg_flat), 32'd0);
        check("rst_edit_val", 32'(edit_val), 32'd0);
        rstn = 1'b1;
        tick();

        // Browse wraps in both directions
        for (int i = 0; i < 7; i++) begin
            if (i < 5) pulse(1'b1, 1'b0, 1'b0);
            else       pulse(1'b0, 1'b1, 1'b0);
            check($sformatf("browse_sel_%0d", i), 32'(sel), 32'(sel_seq[i]));
        end

        // Edit reg 2 to 3 and commit with ready already high
        wr_ready = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        check("sel_2", 32'(sel), 32'd2);
        pulse(1'b0, 1'b0, 1'b1);
        check("edit_enter", 32'(editing), 32'd1);
        check("edit_start_val", 32'(edit_val), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            check($sformatf("edit_up_%0d", i), 32'(edit_val), 32'(i));
        end
        pulse(1'b0, 1'b0, 1'b1);
        check("commit_valid", 32'(wr_valid), 32'd1);
        check("commit_addr", 32'(wr_addr), 32'd2);
        check("commit_data", 32'(wr_data), 32'd3);
        check("commit_cfg_pre", 32'(cfg_flat), 32'h0000);
        tick();
        check("commit_valid_drop", 32'(wr_valid), 32'd0);
        check("commit_cfg", 32'(cfg_flat), 32'h0300);
        check("commit_browse", 32'(editing), 32'd0);
        check("browse_edit_val", 32'(edit_val), 32'd3);

        // Saturate vs wrap at both ends of the range on reg 0
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("sel_0", 32'(sel), 32'd0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check("sat_dn_at_0", 32'(edit_val), 32'd0);
        check("wrap_dn_at_0", 32'(w_edit_val), 32'd15);
        pulse(1'b1, 1'b0, 1'b0);
        check("sat_up_1", 32'(edit_val), 32'd1);
        check("wrap_up_at_max", 32'(w_edit_val), 32'd0);
        repeat (19) pulse(1'b1, 1'b0, 1'b0);
        check("sat_up_max", 32'(edit_val), 32'd15);
        check("wrap_up_19", 32'(w_edit_val), 32'd3);
        pulse(1'b0, 1'b0, 1'b1);
        tick();
        check("sat_cfg", 32'(cfg_flat), 32'h030F);
        check("wrap_cfg", 32'(w_cfg_flat), 32'h0303);

        // Backpressure: commit reg 1 = 2 while ready is low and inputs toggle
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("bp_shadow", 32'(edit_val), 32'd2);
        wr_ready = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            pulse(i % 3 == 0, i % 3 == 1, i % 3 == 2);
            check($sformatf("bp_hold_%0d", i),
                  {wr_valid, 3'b0, 2'b0, wr_addr, wr_data, cfg_flat}, {1'b1, 3'b0, 2'b0, 2'd1, 4'd2, 16'h030F});
        end
        wr_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(wr_valid), 32'd0);
        check("bp_release_cfg", 32'(cfg_flat), 32'h032F);
        check("bp_release_browse", 32'(editing), 32'd0);
        check("bp_release_sel", 32'(sel), 32'd1);

        // Timeout: a step in idle cycle 99 restarts the count
        saw_valid = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("to_shadow", 32'(edit_val), 32'd4);
        for (int i = 0; i < 98; i++) begin
            tick();
            saw_valid |= wr_valid;
        end
        pulse(1'b1, 1'b0, 1'b0);
        check("to_restart_editing", 32'(editing), 32'd1);
        check("to_restart_val", 32'(edit_val), 32'd5);
        for (int i = 0; i < 99; i++) begin
            tick();
            saw_valid |= wr_valid;
        end
        check("to_before_expiry", 32'(editing), 32'd1);
        tick();
        saw_valid |= wr_valid;
        check("to_expired", 32'(editing), 32'd0);
        check("to_cfg_unchanged", 32'(cfg_flat), 32'h032F);
        check("to_edit_val_cfg", 32'(edit_val), 32'd2);
        check("to_no_write", 32'(saw_valid), 32'd0);

        // Cancelling steps, step+press ordering, then reset during a commit
        pulse(1'b1, 1'b1, 1'b0);
        check("cancel_browse", 32'(sel), 32'd1);
        pulse(1'b0, 1'b1, 1'b1);
        check("step_press_sel", 32'(sel), 32'd0);
        check("step_press_editing", 32'(editing), 32'd1);
        check("step_press_val", 32'(edit_val), 32'd15);
        pulse(1'b1, 1'b1, 1'b0);
        check("cancel_edit", 32'(edit_val), 32'd15);
        wr_ready = 1'b0;
        pulse(1'b0, 1'b1, 1'b1);
        check("press_step_valid", 32'(wr_valid), 32'd1);
        check("press_step_data", 32'(wr_data), 32'd15);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(wr_valid), 32'd0);
        check("async_rst_cfg", 32'(cfg_flat), 32'd0);
        check("async_rst_misc", {25'd0, sel, editing, wr_addr, wr_data == 4'd0}, {25'd0, 2'd0, 1'b0, 2'd0, 1'b1});
        check("async_rst_edit_val", 32'(edit_val), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
